// File: rtl/quot_bcd_conv_pkg.sv
// Shared definitions for the quotient BCD converter: FSM state encodings
// (common with the divider control) and a helper that sizes the digit count
// from a binary width.
package quot_bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Number of decimal digits needed to hold 2**n-1.
    function automatic int digits_for_width(input int n);
        longint unsigned max_val;
        int              d;
        max_val = (64'd1 << n) - 64'd1;
        d       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            d       = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/quot_bcd_conv_dabble_core.sv
// bcd_dabble_core: one {BCD,binary} double-dabble working register.
// load  : clear the BCD half and take the binary operand.
// enable: add 3 to every BCD digit >= 5, then shift the pair left one bit.
// bcd_next is the BCD half as it will be after the current shift, so the
// parent can capture the finished result on the same edge as the last shift.
module bcd_dabble_core
    import quot_bcd_conv_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                load,
    input  logic                enable,
    input  logic [N-1:0]        data,
    output logic [4*DIGITS-1:0] bcd_next
);

    logic [4*DIGITS-1:0] bcd_reg;
    logic [N-1:0]        bin_reg;
    logic [4*DIGITS-1:0] adj;
    logic [N-1:0]        bin_next;

    // Add-3 correction per digit; 4-bit add, carry out deliberately dropped.
    always_comb begin
        adj = bcd_reg;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_reg[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_reg[4*d +: 4] + 4'd3;
            end
        end
    end

    // Left shift of the corrected {BCD,binary} pair; the top BCD bit falls off
    // (DIGITS is sized so it is always zero).
    assign {bcd_next, bin_next} = {adj[4*DIGITS-2:0], bin_reg, 1'b0};

    // Working register: load, shift, or hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bcd_reg <= '0;
            bin_reg <= '0;
        end else if (load) begin
            bcd_reg <= '0;
            bin_reg <= data;
        end else if (enable) begin
            bcd_reg <= bcd_next;
            bin_reg <= bin_next;
        end
    end

endmodule

// File: rtl/quot_bcd_conv.sv
// quot_bcd_conv: captures the divider quotient (and optionally remainder) on
// Start and converts it to packed BCD, one bit per cycle.
// Optional feature macro: REM_BCD_EN adds a lockstep datapath for DataR;
// without it DataR is ignored and BCDR is tied to 0.
// Handshake: Start is a level; a conversion begins whenever IDLE samples
// Start=1 on a rising edge. Busy is high for exactly N cycles, then Valid is
// high while in DONE; DONE waits for Start=0 before returning to IDLE, so a
// held Start does not retrigger. BCDQ/BCDR change only on entry to DONE.
module quot_bcd_conv
    import quot_bcd_conv_pkg::*;
#(
    parameter int N      = 8,
    parameter int LOGN   = 3,
    parameter int DIGITS = digits_for_width(N)
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Start,
    input  logic [N-1:0]        DataQ,
    input  logic [N-1:0]        DataR,
    output logic [4*DIGITS-1:0] BCDQ,
    output logic [4*DIGITS-1:0] BCDR,
    output logic                Busy,
    output logic                Valid
);

    // Counter must hold the value N itself, so one bit wider than LOGN.
    localparam int CW = LOGN + 1;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       count;
    logic                load;
    logic                shift_en;
    logic                last_shift;
    logic [4*DIGITS-1:0] q_next;

    assign load       = (state == IDLE) && Start;
    assign shift_en   = (state == SHIFT);
    assign last_shift = shift_en && (count == CW'(1));

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Valid     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = SHIFT;
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last_shift) state_nxt = DONE;
            end
            DONE: begin
                Valid = 1'b1;
                if (!Start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift counter: loaded with N, one decrement per shift.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)       count <= '0;
        else if (load)     count <= CW'(N);
        else if (shift_en) count <= count - CW'(1);
    end

    bcd_dabble_core #(.N(N), .DIGITS(DIGITS)) u_core_q (
        .clock    (Clock),
        .resetn   (Resetn),
        .load     (load),
        .enable   (shift_en),
        .data     (DataQ),
        .bcd_next (q_next)
    );

    // Quotient result register: captured on the final shift, held otherwise.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)         BCDQ <= '0;
        else if (last_shift) BCDQ <= q_next;
    end

`ifdef REM_BCD_EN
    logic [4*DIGITS-1:0] r_next;

    bcd_dabble_core #(.N(N), .DIGITS(DIGITS)) u_core_r (
        .clock    (Clock),
        .resetn   (Resetn),
        .load     (load),
        .enable   (shift_en),
        .data     (DataR),
        .bcd_next (r_next)
    );

    // Remainder result register, in lockstep with the quotient.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)         BCDR <= '0;
        else if (last_shift) BCDR <= r_next;
    end
`else
    logic unused_data_r;
    assign unused_data_r = ^DataR;
    assign BCDR          = '0;
`endif

endmodule

// File: tb/tb_quot_bcd_conv.sv
// Bench for quot_bcd_conv: directed scenarios plus randomized Start/data
// traffic, checked every cycle against a behavioural model.
module tb_quot_bcd_conv;

    localparam int N  = 8;
    localparam int BW = 12;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [N-1:0]  data_q;
    logic [N-1:0]  data_r;
    logic [BW-1:0] bcd_q;
    logic [BW-1:0] bcd_r;
    logic          busy;
    logic          valid;

    int tests = 0;
    int fails = 0;

    quot_bcd_conv dut (
        .Clock  (clk),
        .Resetn (rstn),
        .Start  (start),
        .DataQ  (data_q),
        .DataR  (data_r),
        .BCDQ   (bcd_q),
        .BCDR   (bcd_r),
        .Busy   (busy),
        .Valid  (valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [BW-1:0] rem_expect(input int v);
`ifdef REM_BCD_EN
        return to_bcd(v);
`else
        return 12'h000 + BW'(v & 0);
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // phase 0 = waiting, 1 = converting (cycles_left to go), 2 = result shown
    int            m_phase = 0;
    int            m_left  = 0;
    int            m_pend_q, m_pend_r;
    logic [BW-1:0] m_q = '0;
    logic [BW-1:0] m_r = '0;
    logic [BW-1:0] exp_q[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0;
            m_left  = 0;
            m_q     = '0;
            m_r     = '0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase  = 1;
                    m_left   = N;
                    m_pend_q = int'(data_q);
                    m_pend_r = int'(data_r);
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_q     = to_bcd(m_pend_q);
                        m_r     = rem_expect(m_pend_r);
                        exp_q.push_back(m_q);
                    end
                end
                default: if (!start) m_phase = 0;
            endcase
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic valid_d = 1'b0;
    logic [BW-1:0] exp_v;

    always @(negedge clk) begin
        check("busy",  32'(busy),  32'(m_phase == 1));
        check("valid", 32'(valid), 32'(m_phase == 2));
        check("bcdq",  32'(bcd_q), 32'(m_q));
        check("bcdr",  32'(bcd_r), 32'(m_r));
        if (rstn && valid && !valid_d) begin
            if (exp_q.size() == 0) begin
                check("result_queue_nonempty", 32'(0), 32'(1));
            end else begin
                exp_v = exp_q.pop_front();
                check("result_on_valid", 32'(bcd_q), 32'(exp_v));
            end
        end
        valid_d = valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn  = 1'b0;
        start = 1'b0;
        tick(2);
        @(negedge clk);
        rstn = 1'b1;
        tick(1);
    endtask

    // Start held until the result has been shown, then dropped.
    task automatic convert_held(input logic [N-1:0] q, input logic [N-1:0] r, input int hold);
        data_q = q;
        data_r = r;
        start  = 1'b1;
        tick(hold);
        start  = 1'b0;
        tick(2);
    endtask

    // ---------------- stimulus ----------------
    int busy_cycles;
    int valid_cycles;

    initial begin
        rstn   = 1'b0;
        start  = 1'b0;
        data_q = '0;
        data_r = '0;
        #2;
        check("reset_busy",  32'(busy),  32'(0));
        check("reset_valid", 32'(valid), 32'(0));
        check("reset_bcdq",  32'(bcd_q), 32'(0));
        apply_reset();

        // 255 with Start held: Busy for 8 cycles, then Valid stays up.
        data_q = 8'd255;
        data_r = 8'd3;
        start  = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (busy) busy_cycles++;
        end
        check("held_busy_cycles", 32'(busy_cycles), 32'(8));
        check("held_valid",       32'(valid), 32'(1));
        check("held_bcdq_255",    32'(bcd_q), 32'h255);
        start = 1'b0;
        tick(2);

        // 0 with a one-cycle Start pulse: Valid for exactly one cycle.
        data_q = 8'd0;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        valid_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (valid) valid_cycles++;
        end
        check("pulse_valid_cycles", 32'(valid_cycles), 32'(1));
        check("pulse_bcdq_000",     32'(bcd_q), 32'h000);

        // 100 / 7.
        data_q = 8'd100;
        data_r = 8'd7;
        start  = 1'b1;
        tick(11);
        check("q100_bcdq", 32'(bcd_q), 32'h100);
`ifdef REM_BCD_EN
        check("r7_bcdr",   32'(bcd_r), 32'h007);
`else
        check("r7_bcdr",   32'(bcd_r), 32'h000);
`endif
        start = 1'b0;
        tick(2);

        // Asynchronous reset in the middle of converting 200.
        data_q = 8'd200;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(4);
        #2 rstn = 1'b0;
        #1;
        check("abort_busy",  32'(busy),  32'(0));
        check("abort_valid", 32'(valid), 32'(0));
        check("abort_bcdq",  32'(bcd_q), 32'(0));
        check("abort_bcdr",  32'(bcd_r), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        tick(1);
        data_q = 8'd42;
        start  = 1'b1;
        tick(9);
        check("after_abort_bcdq_042", 32'(bcd_q), 32'h042);
        check("after_abort_valid",    32'(valid), 32'(1));
        start = 1'b0;
        tick(2);

        // Back-to-back: 19, one low cycle in DONE, then 250.
        data_q = 8'd19;
        start  = 1'b1;
        tick(9);
        check("b2b_first_19", 32'(bcd_q), 32'h019);
        start  = 1'b0;
        tick(1);
        data_q = 8'd250;
        start  = 1'b1;
        tick(4);
        check("b2b_hold_19", 32'(bcd_q), 32'h019);
        tick(5);
        check("b2b_second_250", 32'(bcd_q), 32'h250);
        start = 1'b0;
        tick(2);

        // Randomized held conversions.
        for (int i = 0; i < 30; i++) begin
            convert_held(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
                         $urandom_range(1, 14));
        end

        // Random Start level and data every cycle.
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 3) != 0);
            data_q = N'($urandom_range(0, 255));
            data_r = N'($urandom_range(0, 255));
            tick(1);
        end
        start = 1'b0;
        tick(N + 3);
        check("results_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
